// File: rtl/gate_resp_checker.sv
// gate_resp_checker: exercises an external 2-input gate through all four input
// vectors ({a,b} = 00, 01, 10, 11), holds each vector SETTLE_CYCLES cycles,
// then compares the gate output against the GATE_FN truth table.
//
// Ports:
//   clk       - clock, all state changes on rising edge
//   rst_n     - synchronous active-low reset
//   start     - request a full 4-vector check (ignored while busy)
//   dut_y     - output of the gate under test
//   drv_a     - gate input a (index[1] while settling, else 0)
//   drv_b     - gate input b (index[0] while settling, else 0)
//   busy      - check in progress
//   done      - one-cycle pulse when a check completes
//   pass      - last completed check had no mismatches
//   err_count - number of mismatching vectors in last check (0..4)
//   fail_vec  - bit i set when vector i mismatched
module gate_resp_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  GATE_FN       = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_y,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 2;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0] ERR_MAX = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       err_n;
  logic [3:0]       fv_n;
  logic             pass_n;
  logic             drv_a_n, drv_b_n, busy_n, done_n;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_count <= '0;
      fail_vec  <= '0;
      pass      <= 1'b0;
      drv_a     <= 1'b0;
      drv_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      err_count <= err_n;
      fail_vec  <= fv_n;
      pass      <= pass_n;
      drv_a     <= drv_a_n;
      drv_b     <= drv_b_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    err_n   = err_count;
    fv_n    = fail_vec;
    pass_n  = pass;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = SETTLE;
          idx_n   = '0;
          cnt_n   = RELOAD;
          err_n   = '0;
          fv_n    = '0;
          pass_n  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          // Sample point: gate output has had SETTLE_CYCLES cycles to settle
          if (dut_y != GATE_FN[idx_q]) begin
            fv_n[idx_q] = 1'b1;
            if (err_count != ERR_MAX) err_n = err_count + 3'd1;
          end
          if (idx_q != IDX_W'(3)) begin
            idx_n = idx_q + IDX_W'(1);
            cnt_n = RELOAD;
          end else begin
            state_n = DONE;
            // Verdict uses the count including this last compare
            pass_n  = (err_n == 3'd0);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs registered against the upcoming state so they align with it
    drv_a_n = (state_n == SETTLE) & idx_n[1];
    drv_b_n = (state_n == SETTLE) & idx_n[0];
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
  end

endmodule

// File: doc/gate_resp_checker.md
GATE_RESP_CHECKER -- requirements
Module: gate_resp_checker

Interface
- REQ-001: The block SHALL have parameter SETTLE_CYCLES, default 4, giving the cycles each input vector is held before sampling (legal range 1..255).
- REQ-002: The block SHALL have parameter GATE_FN, default 4'b0001, giving the expected truth table: the expected output is GATE_FN[{a,b}] (NOR).
- REQ-003: The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004: The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
- REQ-005: The block SHALL have port start, input, 1 bit: request a full 4-vector check.
- REQ-006: The block SHALL have port dut_y, input, 1 bit: output of the 2-input gate under test.
- REQ-007: The block SHALL have ports drv_a and drv_b, each output, 1 bit: drive the gate-under-test inputs a and b.
- REQ-008: The block SHALL have port busy, output, 1 bit: high while a check is in progress.
- REQ-009: The block SHALL have port done, output, 1 bit: one-cycle pulse when a check completes.
- REQ-010: The block SHALL have port pass, output, 1 bit: high when the last completed check had zero mismatches.
- REQ-011: The block SHALL have port err_count, output, 3 bits: number of mismatching vectors in the last check (0..4).
- REQ-012: The block SHALL have port fail_vec, output, 4 bits: bit i set when vector i ({a,b}=i) mismatched.

Function
- REQ-013: The block SHALL implement the FSM states IDLE, SETTLE, DONE.
- REQ-014: In IDLE, start=1 SHALL be accepted: the next state is SETTLE, the vector index is 0, the settle counter is loaded with SETTLE_CYCLES-1, err_count is cleared to 0, fail_vec is cleared to 0 and pass is cleared to 0.
- REQ-015: Vector order SHALL be {a,b} = 00, 01, 10, 11, with drv_a/drv_b = index[1]/index[0] in SETTLE.
- REQ-016: In SETTLE, the counter SHALL decrement each cycle while nonzero.
- REQ-017: In the SETTLE cycle where the counter is 0, dut_y SHALL be compared with GATE_FN[index].
  - On a mismatch, fail_vec[index] is set and err_count increments.
- REQ-018: After the compare, if index < 3 the index SHALL increment and the counter SHALL reload to SETTLE_CYCLES-1 while staying in SETTLE; if index = 3 the next state SHALL be DONE.
- REQ-019: In DONE, done SHALL be 1 for exactly one cycle, pass SHALL be (err_count==0) using the final count including the last compare, and the next state SHALL be IDLE.
- REQ-020: busy SHALL be 1 in SETTLE and DONE and 0 in IDLE.
- REQ-021: drv_a and drv_b SHALL be 0 in IDLE and DONE.
- REQ-022: Latency: with start accepted at edge T, each vector SHALL occupy exactly SETTLE_CYCLES cycles, and done SHALL be high in the cycle after edge T+4*SETTLE_CYCLES (i.e. the check takes 4*SETTLE_CYCLES+1 cycles including DONE).
- REQ-023: start SHALL be ignored while busy=1, including start asserted in the DONE cycle.
- REQ-024: start held high continuously SHALL cause back-to-back checks separated by exactly one IDLE cycle.
- REQ-025: pass, err_count and fail_vec SHALL hold their values from DONE until the next accepted start.
- REQ-026: err_count SHALL NOT wrap: its maximum is 4.

Reset
- REQ-027: When rst_n=0 at a rising edge, the state SHALL become IDLE and all outputs SHALL be 0: drv_a, drv_b, busy, done, pass, err_count, fail_vec, plus the internal index and counter.
- REQ-028: Reset SHALL take priority over start and over any in-progress check; a check aborted by reset produces no done pulse.

Verification
- REQ-029: Correct NOR model, SETTLE_CYCLES=4, start pulsed at edge T -> done at cycle T+17, pass=1, err_count=0, fail_vec=0000.
- REQ-030: dut_y stuck at 0 -> done with pass=0, err_count=1, fail_vec=0001.
- REQ-031: dut_y stuck at 1 -> pass=0, err_count=3, fail_vec=1110.
- REQ-032: OR model with GATE_FN=4'b1110, SETTLE_CYCLES=1 -> done at cycle T+5, pass=1; drv_a/drv_b sequence 00,01,10,11 with one cycle each.
- REQ-033: Second start pulse during busy -> ignored; exactly one done pulse, timing unchanged.
- REQ-034: rst_n=0 during vector 2 -> all outputs 0 next cycle, no done; a subsequent start gives a full correct check.
